// File: rtl/hex_display_sched.sv
// hex_display_sched: round-robin scheduler sharing one bank of DIGITS
// seven-segment displays between NUM_SRC requesters.
//
// Each valid source is shown for DWELL_CYCLES clocks, then the scheduler
// rotates to the next valid source. 'lock' freezes the dwell timer and
// 'next' forces an immediate rotation. All outputs are registered, with
// one cycle of latency from the sampled inputs.
//
// Optional build macro: HEX_SCHED_LZB_EN
//   When defined, leading-zero blanking is enabled: every digit above the
//   most significant nonzero nibble is blanked, and digit 0 is never
//   blanked. When undefined, no digit is blanked while a source is shown.

module hex_display_sched #(
    parameter int NUM_SRC      = 4,
    parameter int DIGITS       = 6,
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DIGITS*4-1:0]   src_data,
    input  logic                          lock,
    input  logic                          next,
    output logic [NUM_SRC-1:0]            grant,
    output logic [$clog2(NUM_SRC)-1:0]    sel,
    output logic [DIGITS*4-1:0]           disp_nibbles,
    output logic [DIGITS-1:0]             disp_blank
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int NIB_W = DIGITS * 4;

    // Terminal count of the dwell timer: it runs 0 .. DWELL_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [NIB_W-1:0] NIB_ZERO  = {NIB_W{1'b0}};
    localparam logic [DIGITS-1:0] BLANK_ALL = {DIGITS{1'b1}};
    localparam logic [DIGITS-1:0] BLANK_NONE = {DIGITS{1'b0}};
    localparam logic [NUM_SRC-1:0] GRANT_NONE = {NUM_SRC{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [SEL_W-1:0]  nxt_sel_s;
    logic [NIB_W-1:0]  cur_nib_s;
    logic [DIGITS-1:0] cur_blank_s;
    logic              any_valid_s;
    logic              expire_s;
    logic              advance_s;

    // First valid index in the order cur+1, cur+2, ... wrapping, with cur
    // itself examined last. Scanning from the farthest candidate down to the
    // nearest and overwriting leaves the nearest valid one. If nothing is
    // valid the current index is returned unchanged.
    function automatic logic [SEL_W-1:0] next_valid(
        input logic [SEL_W-1:0]   cur,
        input logic [NUM_SRC-1:0] valid
    );
        logic [SEL_W-1:0] pick;
        int               idx;
        pick = cur;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(cur) + k) % NUM_SRC;
            if (valid[idx]) begin
                pick = SEL_W'(idx);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // One-hot grant vector for a source index.
    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] vec;
        vec      = GRANT_NONE;
        vec[idx] = 1'b1;
        return vec;
    endfunction

`ifdef HEX_SCHED_LZB_EN
    // Leading-zero blank mask: a digit is blanked while every digit above it
    // (and itself) is zero. Digit 0 is always shown so a zero value reads "0".
    function automatic logic [DIGITS-1:0] lzb_mask(input logic [NIB_W-1:0] nib);
        logic [DIGITS-1:0] mask;
        logic              seen;
        mask = BLANK_NONE;
        seen = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (nib[d*4 +: 4] != 4'h0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            mask[d] = ~seen;
        end
        return mask;
    endfunction
`endif

    // Decode the current source's data, its blank mask and the advance request.
    always_comb begin
        nxt_sel_s   = next_valid(sel, src_valid);
        cur_nib_s   = src_data[int'(sel)*NIB_W +: NIB_W];
`ifdef HEX_SCHED_LZB_EN
        cur_blank_s = lzb_mask(cur_nib_s);
`else
        cur_blank_s = BLANK_NONE;
`endif
        any_valid_s = |src_valid;
        expire_s    = (cnt_r == CNT_LAST) && !lock;
        // A dropped source always advances, even under lock.
        advance_s   = expire_s || next || !src_valid[sel];
    end

    // Scheduler state machine with registered grant, select and display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sel          <= SEL_ZERO;
            grant        <= GRANT_NONE;
            cnt_r        <= CNT_ZERO;
            disp_nibbles <= NIB_ZERO;
            disp_blank   <= BLANK_ALL;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    disp_nibbles <= NIB_ZERO;
                    disp_blank   <= BLANK_ALL;
                    if (any_valid_s) begin
                        state_r <= ST_SHOW;
                        sel     <= nxt_sel_s;
                        grant   <= onehot(nxt_sel_s);
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        grant   <= GRANT_NONE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_SHOW: begin
                    // Data is sampled live every cycle; no snapshot is held.
                    disp_nibbles <= cur_nib_s;
                    disp_blank   <= cur_blank_s;
                    if (advance_s) begin
                        cnt_r <= CNT_ZERO;
                        if (any_valid_s) begin
                            // Sole valid source re-selects itself; only the timer restarts.
                            sel   <= nxt_sel_s;
                            grant <= onehot(nxt_sel_s);
                        end else begin
                            // Nothing left to show: blank now, keep the last sel.
                            state_r      <= ST_IDLE;
                            grant        <= GRANT_NONE;
                            disp_nibbles <= NIB_ZERO;
                            disp_blank   <= BLANK_ALL;
                        end
                    end else if (!lock) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    sel          <= SEL_ZERO;
                    grant        <= GRANT_NONE;
                    cnt_r        <= CNT_ZERO;
                    disp_nibbles <= NIB_ZERO;
                    disp_blank   <= BLANK_ALL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_sched.sv
// Self-checking bench for hex_display_sched (NUM_SRC=4, DIGITS=6,
// DWELL_CYCLES=4). A behavioural model is compared against the DUT every
// cycle, and directed scenarios add hand-computed literal expectations.
// Honours HEX_SCHED_LZB_EN in the same way as the design.

module tb_hex_display_sched;

    localparam int NS = 4;
    localparam int DG = 6;
    localparam int DW = 4;
    localparam int CW = 3;

`ifdef HEX_SCHED_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_valid;
    logic [95:0] src_data;
    logic        lock;
    logic        next;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [23:0] disp_nibbles;
    logic [5:0]  disp_blank;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    logic [23:0] d0, d1, d2, d3;

    hex_display_sched #(
        .NUM_SRC(NS), .DIGITS(DG), .DWELL_CYCLES(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
        .lock(lock), .next(next), .grant(grant), .sel(sel),
        .disp_nibbles(disp_nibbles), .disp_blank(disp_blank)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: nearest valid index after cur, cur itself last.
    function automatic int pick(input int cur, input logic [3:0] v);
        for (int k = 1; k <= NS; k++) begin
            if (v[(cur + k) % NS]) return (cur + k) % NS;
        end
        return cur;
    endfunction

    // Expected blank mask for a shown value.
    function automatic logic [5:0] lzb(input logic [23:0] n);
        int top;
        top = 0;
        for (int d = 0; d < DG; d++) begin
            if (n[d*4 +: 4] != 4'h0) top = d;
        end
        if (LZB) return 6'h3f & ~6'((1 << (top + 1)) - 1);
        return 6'h00;
    endfunction

    // Model state: showing flag, selected source, dwell count, displayed value.
    bit          m_show, n_show;
    int          m_sel,  n_sel;
    int          m_cnt,  n_cnt;
    logic [23:0] m_nib,  n_nib;
    logic [5:0]  m_blank, n_blank;

    // Model next state from the inputs present at the coming edge.
    always_comb begin
        n_show  = m_show;
        n_sel   = m_sel;
        n_cnt   = m_cnt;
        n_nib   = m_nib;
        n_blank = m_blank;
        if (reset) begin
            n_show = 1'b0; n_sel = 0; n_cnt = 0; n_nib = 24'h0; n_blank = 6'h3f;
        end else if (!m_show) begin
            n_nib = 24'h0; n_blank = 6'h3f;
            if (src_valid != 4'b0000) begin
                n_show = 1'b1; n_sel = pick(m_sel, src_valid); n_cnt = 0;
            end
        end else begin
            n_nib   = src_data[m_sel*24 +: 24];
            n_blank = lzb(n_nib);
            if (src_valid == 4'b0000) begin
                n_show = 1'b0; n_cnt = 0; n_nib = 24'h0; n_blank = 6'h3f;
            end else if (next || !src_valid[m_sel] || (!lock && m_cnt == DW - 1)) begin
                n_sel = pick(m_sel, src_valid); n_cnt = 0;
            end else if (!lock) begin
                n_cnt = m_cnt + 1;
            end
        end
    end

    // Model state update.
    always @(posedge clk) begin
        m_show  <= n_show;
        m_sel   <= n_sel;
        m_cnt   <= n_cnt;
        m_nib   <= n_nib;
        m_blank <= n_blank;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant", 32'(grant), m_show ? (32'd1 << m_sel) : 32'd0);
            chk("model_sel", 32'(sel), 32'(m_sel));
            chk("model_nibbles", 32'(disp_nibbles), 32'(m_nib));
            chk("model_blank", 32'(disp_blank), 32'(m_blank));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data;
        src_data = {d3, d2, d1, d0};
    endtask

    // Directed scenarios with literal expectations.
    initial begin
        reset = 1'b1; src_valid = 4'b0000; lock = 1'b0; next = 1'b0;
        d0 = 24'h123456; d1 = 24'h0F0000; d2 = 24'h00ABCD; d3 = 24'h000007;
        set_data();
        step(1);
        cmp_en = 1'b1;
        step(1);
        reset = 1'b0;
        step(10);
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_sel", 32'(sel), 32'h0);
        chk("idle_nibbles", 32'(disp_nibbles), 32'h0);
        chk("idle_blank", 32'(disp_blank), 32'h3f);

        // Two sources rotating.
        src_valid = 4'b0101;
        step(1);
        chk("rr_first_grant", 32'(grant), 32'h4);
        chk("rr_first_blank", 32'(disp_blank), 32'h3f);
        step(1);
        chk("rr_data2", 32'(disp_nibbles), 32'h00ABCD);
        chk("rr_blank2", 32'(disp_blank), LZB ? 32'h30 : 32'h0);
        step(3);
        chk("rr_rotate_grant", 32'(grant), 32'h1);
        chk("rr_data_lag", 32'(disp_nibbles), 32'h00ABCD);
        step(1);
        chk("rr_data0", 32'(disp_nibbles), 32'h123456);
        step(8);

        // Reset mid-SHOW, then lock hold and forced advance.
        reset = 1'b1;
        step(1);
        chk("midreset_grant", 32'(grant), 32'h0);
        chk("midreset_blank", 32'(disp_blank), 32'h3f);
        chk("midreset_nibbles", 32'(disp_nibbles), 32'h0);
        reset = 1'b0; src_valid = 4'b1111; lock = 1'b1;
        step(1);
        chk("lock_enter_grant", 32'(grant), 32'h2);
        step(20);
        chk("lock_hold_grant", 32'(grant), 32'h2);
        next = 1'b1; lock = 1'b0;
        step(1);
        next = 1'b0;
        chk("next_grant", 32'(grant), 32'h4);
        step(3);
        chk("restart_hold", 32'(grant), 32'h4);
        step(1);
        chk("restart_expire", 32'(grant), 32'h8);

        // Drop of the current source while locked.
        lock = 1'b1; next = 1'b1;
        step(3);
        next = 1'b0;
        chk("walk_sel", 32'(sel), 32'h2);
        src_valid = 4'b1011;
        step(1);
        chk("drop_sel3", 32'(sel), 32'h3);
        src_valid = 4'b0111;
        step(1);
        chk("drop_wrap0", 32'(sel), 32'h0);
        next = 1'b1;
        step(2);
        next = 1'b0;
        src_valid = 4'b0011;
        step(1);
        chk("drop_wrap_low", 32'(grant), 32'h1);
        src_valid = 4'b0010;
        step(1);
        chk("drop_to1", 32'(sel), 32'h1);
        src_valid = 4'b0000;
        step(1);
        chk("all_drop_grant", 32'(grant), 32'h0);
        chk("all_drop_blank", 32'(disp_blank), 32'h3f);
        chk("all_drop_sel_kept", 32'(sel), 32'h1);
        step(1);

        // Forced advance coinciding with dwell expiry: one step only.
        lock = 1'b0; src_valid = 4'b0011;
        step(1);
        chk("exp_enter", 32'(grant), 32'h1);
        step(3);
        next = 1'b1;
        step(1);
        next = 1'b0;
        chk("exp_next_single", 32'(sel), 32'h1);
        step(1);
        chk("exp_next_hold", 32'(grant), 32'h2);

        // Leading-zero blanking patterns.
        d0 = 24'h0000A0; set_data();
        src_valid = 4'b0001;
        step(1);
        chk("lzb_sel", 32'(sel), 32'h0);
        step(1);
        chk("lzb_a0_nib", 32'(disp_nibbles), 32'h0000A0);
        chk("lzb_a0_blank", 32'(disp_blank), LZB ? 32'h3c : 32'h0);
        d0 = 24'h000000; set_data();
        step(1);
        chk("lzb_zero_blank", 32'(disp_blank), LZB ? 32'h3e : 32'h0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
